// File: rtl/nn_timestep_sequencer.sv
// Timestep sequencer for a spiking network: buffers input spike frames, injects one per step,
// integrates output spikes over a window per step and reports per-neuron spike counts.
module nn_timestep_sequencer #(
    parameter int unsigned NUM_NEURONS  = 4,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned COUNT_WIDTH  = 8,
    parameter int unsigned WINDOW_WIDTH = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               frame_valid,
    output logic                               frame_ready,
    input  logic [NUM_NEURONS-1:0]             frame_data,
    input  logic                               start,
    input  logic                               abort,
    input  logic [7:0]                         num_steps,
    input  logic [WINDOW_WIDTH-1:0]            window,
    output logic                               nn_reset_n,
    output logic [NUM_NEURONS-1:0]             nn_input_spikes,
    input  logic [NUM_NEURONS-1:0]             nn_output_spikes,
    output logic [NUM_NEURONS*COUNT_WIDTH-1:0] spike_count,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_level
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CLEAR     = 3'd1;
    localparam logic [2:0] S_INJECT    = 3'd2;
    localparam logic [2:0] S_INTEGRATE = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    logic [2:0]                         state_q, state_d;
    logic [7:0]                         steps_q, step_cnt_q, step_inc;
    logic [WINDOW_WIDTH-1:0]            window_q, win_cnt_q, win_load;
    logic                               injecting_q;
    logic [PTR_W-1:0]                   wr_ptr_q, rd_ptr_q;
    logic [NUM_NEURONS-1:0]             mem_q [FIFO_DEPTH];
    logic [NUM_NEURONS-1:0]             head;
    logic [LVL_W-1:0]                   level_d;
    logic [NUM_NEURONS*COUNT_WIDTH-1:0] count_d;
    logic                               abort_run, push, pop, last_win;

    assign abort_run = abort && (state_q != S_IDLE);
    assign push      = frame_valid && frame_ready && !abort_run;
    assign last_win  = (win_cnt_q == WINDOW_WIDTH'(1));
    assign win_load  = (window_q == '0) ? WINDOW_WIDTH'(1) : window_q;
    assign step_inc  = step_cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start) state_d = S_CLEAR;
            S_CLEAR:     state_d = (steps_q == 8'd0) ? S_DONE : S_INJECT;
            S_INJECT:    if (injecting_q) state_d = S_INTEGRATE;
            S_INTEGRATE: if (last_win) state_d = (step_inc == steps_q) ? S_DONE : S_INJECT;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
        if (abort_run) state_d = S_IDLE;
    end

    // A frame arriving into an empty FIFO is forwarded directly, so the pop can coincide with it.
    assign pop  = (state_d == S_INJECT) && ((fifo_level != '0) || push);
    assign head = (fifo_level == '0) ? frame_data : mem_q[rd_ptr_q];

    always_comb begin
        level_d = fifo_level;
        if (abort_run)          level_d = '0;
        else if (push && !pop)  level_d = fifo_level + LVL_W'(1);
        else if (pop && !push)  level_d = fifo_level - LVL_W'(1);
    end

    always_comb begin
        count_d = spike_count;
        if (state_d == S_CLEAR) begin
            count_d = '0;
        end else if (state_q == S_INTEGRATE && !abort_run) begin
            for (int i = 0; i < int'(NUM_NEURONS); i++) begin
                if (nn_output_spikes[i] && spike_count[i*COUNT_WIDTH +: COUNT_WIDTH] != '1)
                    count_d[i*COUNT_WIDTH +: COUNT_WIDTH] =
                        spike_count[i*COUNT_WIDTH +: COUNT_WIDTH] + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= frame_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            steps_q         <= '0;
            window_q        <= '0;
            step_cnt_q      <= '0;
            win_cnt_q       <= '0;
            injecting_q     <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            fifo_level      <= '0;
            frame_ready     <= 1'b0;
            nn_reset_n      <= 1'b0;
            nn_input_spikes <= '0;
            spike_count     <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                steps_q  <= num_steps;
                window_q <= window;
            end
            if (state_d == S_CLEAR) begin
                step_cnt_q <= '0;
            end else if (state_q == S_INTEGRATE && last_win && !abort_run) begin
                step_cnt_q <= step_inc;
            end
            if (state_q == S_INJECT && injecting_q && !abort_run) begin
                win_cnt_q <= win_load;
            end else if (state_q == S_INTEGRATE && !abort_run) begin
                win_cnt_q <= win_cnt_q - WINDOW_WIDTH'(1);
            end
            if (abort_run) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            fifo_level      <= level_d;
            frame_ready     <= (level_d < LVL_W'(FIFO_DEPTH));
            injecting_q     <= pop;
            nn_input_spikes <= pop ? head : '0;
            nn_reset_n      <= (state_d != S_CLEAR);
            spike_count     <= count_d;
            busy            <= (state_d != S_IDLE);
            done            <= (state_d == S_DONE);
        end
    end

endmodule

// File: tb/tb_nn_timestep_sequencer.sv
// Scoreboarded bench: expected injected frames and final spike counts are queued by the
// stimulus and compared by an independent monitor when the sequencer presents them.
module tb_nn_timestep_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_valid, frame_ready, start, abort;
    logic [3:0]  frame_data, nn_input_spikes, nn_output_spikes;
    logic [7:0]  num_steps, window;
    logic        nn_reset_n, busy, done;
    logic [31:0] spike_count;
    logic [3:0]  fifo_level;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0]  exp_inj [$];
    logic [31:0] exp_cnt [$];

    nn_timestep_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .frame_valid      (frame_valid),
        .frame_ready      (frame_ready),
        .frame_data       (frame_data),
        .start            (start),
        .abort            (abort),
        .num_steps        (num_steps),
        .window           (window),
        .nn_reset_n       (nn_reset_n),
        .nn_input_spikes  (nn_input_spikes),
        .nn_output_spikes (nn_output_spikes),
        .spike_count      (spike_count),
        .busy             (busy),
        .done             (done),
        .fifo_level       (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: a neuron firing every cycle accumulates steps*max(window,1), clipped at 255.
    function automatic logic [31:0] model_counts(input int steps, input int w, input logic [3:0] o);
        int per;
        logic [31:0] r;
        per = steps * ((w == 0) ? 1 : w);
        if (per > 255) per = 255;
        r = '0;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = o[i] ? 8'(per) : 8'd0;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (nn_input_spikes != 4'd0) begin
                if (exp_inj.size() == 0) check("unexpected_inject", 32'(nn_input_spikes), 32'd0);
                else check("inject_frame", 32'(nn_input_spikes), 32'(exp_inj.pop_front()));
            end
            if (done) begin
                if (exp_cnt.size() == 0) check("unexpected_done", 32'(done), 32'd0);
                else check("done_counts", spike_count, exp_cnt.pop_front());
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_nn_reset_n"}, 32'(nn_reset_n), 32'd0);
        check({tag, "_inject"}, 32'(nn_input_spikes), 32'd0);
        check({tag, "_counts"}, spike_count, 32'd0);
        check({tag, "_level"}, 32'(fifo_level), 32'd0);
        check({tag, "_ready"}, 32'(frame_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic push_frame(input logic [3:0] f);
        int t = 0;
        frame_valid = 1'b1;
        frame_data  = f;
        while (!frame_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("push_accept", 32'(frame_ready), 32'd1);
        if (frame_ready) exp_inj.push_back(f);
        @(negedge clk);
        frame_valid = 1'b0;
    endtask

    task automatic do_start(input int steps, input int w, input logic [3:0] o);
        nn_output_spikes = o;
        num_steps        = 8'(steps);
        window           = 8'(w);
        start            = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < budget);
        check("done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        int cyc, lvl, w, steps, pre;
        logic [3:0] o;
        rst_n = 1'b0; frame_valid = 1'b0; frame_data = '0; start = 1'b0; abort = 1'b0;
        num_steps = '0; window = '0; nn_output_spikes = '0;
        #2 check_reset_vals("rst_pre_clk");
        #25 check_reset_vals("rst_with_clk");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_nn_reset_n", 32'(nn_reset_n), 32'd1);
        check("post_rst_ready", 32'(frame_ready), 32'd1);

        // Two-step run with prefilled FIFO: exact done latency and count of 6 on neuron 0
        push_frame(4'b0001);
        push_frame(4'b1000);
        exp_cnt.push_back(model_counts(2, 3, 4'b0001));
        do_start(2, 3, 4'b0001);
        wait_done(40, cyc);
        check("done_latency_2x3", 32'(cyc), 32'd9);
        @(negedge clk);

        // Empty FIFO stalls in INJECT; late frame bypasses straight to the network
        exp_cnt.push_back(model_counts(1, 4, 4'b1010));
        do_start(1, 4, 4'b1010);
        repeat (4) @(negedge clk);
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_no_inject", 32'(nn_input_spikes), 32'd0);
        check("stall_counts", spike_count, 32'd0);
        push_frame(4'b0110);
        check("bypass_level", 32'(fifo_level), 32'd0);
        check("bypass_inject", 32'(nn_input_spikes), 32'h6);
        wait_done(40, cyc);
        check("stall_done_latency", 32'(cyc), 32'd5);
        @(negedge clk);

        // Nine back-to-back offers into an idle FIFO of depth 8
        lvl = 0;
        for (int k = 0; k < 9; k++) begin
            frame_valid = 1'b1;
            frame_data  = 4'($urandom_range(1, 15));
            check("fill_ready", 32'(frame_ready), (lvl < 8) ? 32'd1 : 32'd0);
            if (lvl < 8) begin
                exp_inj.push_back(frame_data);
                lvl++;
            end
            @(negedge clk);
            check("fill_level", 32'(fifo_level), 32'(lvl));
        end
        frame_valid = 1'b0;
        check("full_ready_low", 32'(frame_ready), 32'd0);
        w = $urandom_range(0, 3);
        o = 4'($urandom);
        exp_cnt.push_back(model_counts(8, w, o));
        do_start(8, w, o);
        wait_done(200, cyc);
        check("drain_latency", 32'(cyc), 32'(1 + 8 * (1 + ((w == 0) ? 1 : w))));
        @(negedge clk);

        // Saturation
        push_frame(4'h3);
        push_frame(4'hC);
        exp_cnt.push_back(model_counts(2, 200, 4'hF));
        do_start(2, 200, 4'hF);
        wait_done(1000, cyc);
        @(negedge clk);

        // Abort in the first INTEGRATE of a three-step run
        push_frame(4'h9);
        push_frame(4'h2);
        push_frame(4'h4);
        do_start(3, 5, 4'b0011);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        nn_output_spikes = 4'b0000;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_level", 32'(fifo_level), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_partial_counts", spike_count, 32'h0000_0101);
        exp_inj.delete();
        repeat (5) @(negedge clk);
        exp_cnt.push_back(32'd0);
        do_start(0, 5, 4'b0011);
        check("zero_steps_clear", 32'(nn_reset_n), 32'd0);
        check("zero_steps_counts", spike_count, 32'd0);
        wait_done(5, cyc);
        check("zero_steps_latency", 32'(cyc), 32'd1);
        check("zero_steps_reset_hi", 32'(nn_reset_n), 32'd1);
        @(negedge clk);

        // Randomized runs with frames arriving before and during the run
        for (int r = 0; r < 8; r++) begin
            steps = $urandom_range(1, 4);
            w     = $urandom_range(0, 6);
            o     = 4'($urandom);
            pre   = $urandom_range(0, steps);
            for (int k = 0; k < pre; k++) push_frame(4'($urandom_range(1, 15)));
            exp_cnt.push_back(model_counts(steps, w, o));
            do_start(steps, w, o);
            for (int k = pre; k < steps; k++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                push_frame(4'($urandom_range(1, 15)));
            end
            if (!done) wait_done(200, cyc);
            @(negedge clk);
        end

        // Reset mid-INTEGRATE takes effect without a clock edge
        push_frame(4'h5);
        do_start(1, 10, 4'h1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst_mid_run");
        exp_inj.delete();
        exp_cnt.delete();
        #20 check_reset_vals("rst_mid_run_held");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("rerst_nn_reset_n", 32'(nn_reset_n), 32'd1);
        check("rerst_ready", 32'(frame_ready), 32'd1);
        repeat (20) @(negedge clk);

        check("inject_queue_drained", 32'(exp_inj.size()), 32'd0);
        check("count_queue_drained", 32'(exp_cnt.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
